// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types, defaults and parity helper
package uart_pkg;
  localparam int UART_SIZE = 8;
  localparam int UART_OVERSAMPLE = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  function automatic logic parity_mismatch(input logic data_xor, input logic par_bit, input logic odd);
    return data_xor ^ par_bit ^ odd;
  endfunction
endpackage

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: tick-gated oversample counter with mid-bit and terminal pulses
module uart_rx_bit_timer import uart_pkg::*; #(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  localparam int W = $clog2(OVERSAMPLE)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         mid,
  output logic         fin
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (tick) cnt <= (clr || cnt == term) ? '0 : cnt + 1'b1;
  assign mid = tick && cnt == W'(OVERSAMPLE/2-1);
  assign fin = tick && cnt == term;
endmodule

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: start detect, bit sampling, parity/stop check and valid/ready output
module uart_rx_sequencer import uart_pkg::*; #(
  parameter int SIZE = UART_SIZE,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            rxd,
  input  logic            ready,
  output logic [SIZE-1:0] data,
  output logic            valid,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(SIZE+1);
  rx_state_t       state;
  logic            rxd_prev, perr, mid, fin;
  logic [SIZE-1:0] shreg;
  logic [BW-1:0]   bit_cnt;
  logic [TW-1:0]   term;
  // start bit only runs to its midpoint; every later bit runs a full period
  assign term = (state == START) ? TW'(OVERSAMPLE/2-1) : TW'(OVERSAMPLE-1);
  uart_rx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clr(state == IDLE),
    .term(term), .mid(mid), .fin(fin)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rxd_prev <= 1'b1;
      shreg <= '0;
      bit_cnt <= '0;
      perr <= 1'b0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (valid && ready) begin
        valid <= 1'b0;
        overrun <= 1'b0;
      end
      if (tick) begin
        rxd_prev <= rxd;
        case (state)
          IDLE: if (rxd_prev && !rxd) begin
            state <= START;
            busy <= 1'b1;
          end
          START: if (mid) begin
            if (rxd) begin
              state <= IDLE;
              busy <= 1'b0;
            end else begin
              state <= DATA;
              bit_cnt <= '0;
              perr <= 1'b0;
            end
          end
          DATA: if (fin) begin
            shreg <= {rxd, shreg[SIZE-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(SIZE-1)) state <= PARITY_EN ? PARITY : STOP;
          end
          PARITY: if (fin) begin
            perr <= parity_mismatch(^shreg, rxd, PARITY_ODD);
            state <= STOP;
          end
          STOP: if (fin) begin
            state <= IDLE;
            busy <= 1'b0;
            // a held frame that is not being accepted this cycle wins over the new one
            if (!valid || ready) begin
              data <= shreg;
              frame_err <= ~rxd;
              parity_err <= perr;
              valid <= 1'b1;
              overrun <= 1'b0;
            end else overrun <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb_uart_rx_sequencer: directed frames against default and even-parity receivers
module tb_uart_rx_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, rxd = 1'b1, ready = 1'b0;
  logic [7:0] data0, data1;
  logic valid0, frame_err0, parity_err0, overrun0, busy0;
  logic valid1, frame_err1, parity_err1, overrun1, busy1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  uart_rx_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rxd(rxd), .ready(ready),
    .data(data0), .valid(valid0), .frame_err(frame_err0), .parity_err(parity_err0),
    .overrun(overrun0), .busy(busy0)
  );
  uart_rx_sequencer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rxd(rxd), .ready(ready),
    .data(data1), .valid(valid1), .frame_err(frame_err1), .parity_err(parity_err1),
    .overrun(overrun1), .busy(busy1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ticks(input logic b, input int n);
    rxd = b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask
  task automatic frame(input logic [8:0] d, input int n, input logic stop, input int st);
    ticks(1'b0, 16);
    for (int i = 0; i < n; i++) ticks(d[i], 16);
    ticks(stop, st);
  endtask
  task automatic pulse_ready();
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
  endtask
  initial begin
    logic [8:0] v;
    #1;
    chk("rst_valid", valid0, 0);
    chk("rst_all", {data0, valid0, frame_err0, parity_err0, overrun0, busy0}, 0);
    @(negedge clk) rst_n = 1'b1;
    ticks(1'b1, 4);
    // 0xA5 with exact stop-sample timing
    ready = 1'b1;
    v = 9'h0A5;
    ticks(1'b0, 1);
    chk("a5_busy", busy0, 1);
    ticks(1'b0, 15);
    for (int i = 0; i < 8; i++) ticks(v[i], 16);
    ticks(1'b1, 8);
    chk("a5_early", valid0, 0);
    ticks(1'b1, 1);
    chk("a5_valid", valid0, 1);
    chk("a5_data", data0, 8'hA5);
    chk("a5_ferr", frame_err0, 0);
    chk("a5_perr", parity_err0, 0);
    @(negedge clk);
    chk("a5_drop", valid0, 0);
    ticks(1'b1, 16);
    // start glitch
    ticks(1'b0, 4);
    ticks(1'b1, 4);
    chk("gl_busy", busy0, 1);
    ticks(1'b1, 1);
    chk("gl_idle", busy0, 0);
    ticks(1'b1, 16);
    chk("gl_valid", valid0, 0);
    // framing error, line held low
    ready = 1'b0;
    frame(9'h03C, 8, 1'b0, 9);
    ticks(1'b0, 40);
    chk("fe_valid", valid0, 1);
    chk("fe_data", data0, 8'h3C);
    chk("fe_ferr", frame_err0, 1);
    chk("fe_noretrig", busy0, 0);
    pulse_ready();
    chk("fe_accept", valid0, 0);
    ticks(1'b1, 16);
    ticks(1'b0, 1);
    chk("fe_retrig", busy0, 1);
    ticks(1'b0, 15);
    v = 9'h011;
    for (int i = 0; i < 8; i++) ticks(v[i], 16);
    ticks(1'b1, 9);
    chk("ov_data1", data0, 8'h11);
    chk("ov_ferr1", frame_err0, 0);
    ticks(1'b1, 16);
    // overrun
    frame(9'h022, 8, 1'b1, 16);
    ticks(1'b1, 16);
    chk("ov_keep", data0, 8'h11);
    chk("ov_valid", valid0, 1);
    chk("ov_flag", overrun0, 1);
    pulse_ready();
    chk("ov_acc_valid", valid0, 0);
    chk("ov_acc_flag", overrun0, 0);
    // completion coinciding with accept
    frame(9'h011, 8, 1'b1, 16);
    frame(9'h022, 8, 1'b1, 8);
    chk("sim_pre", data0, 8'h11);
    @(negedge clk) begin tick = 1'b1; ready = 1'b1; end
    @(negedge clk) begin tick = 1'b0; ready = 1'b0; end
    chk("sim_data", data0, 8'h22);
    chk("sim_valid", valid0, 1);
    chk("sim_ovr", overrun0, 0);
    ticks(1'b1, 16);
    // reset mid-DATA
    ticks(1'b0, 16);
    ticks(1'b1, 16);
    ticks(1'b0, 16);
    ticks(1'b1, 5);
    chk("mr_busy", busy0, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mr_valid", valid0, 0);
    chk("mr_all", {data0, valid0, frame_err0, parity_err0, overrun0, busy0}, 0);
    @(negedge clk) rst_n = 1'b1;
    ticks(1'b1, 4);
    frame(9'h05A, 8, 1'b1, 9);
    chk("mr_data", data0, 8'h5A);
    chk("mr_rvalid", valid0, 1);
    chk("mr_ferr", frame_err0, 0);
    ticks(1'b1, 16);
    pulse_ready();
    // even parity
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    ticks(1'b1, 4);
    ready = 1'b1;
    frame(9'h007, 9, 1'b1, 9);
    chk("p0_valid", valid1, 1);
    chk("p0_data", data1, 8'h07);
    chk("p0_perr", parity_err1, 1);
    chk("p0_ferr", frame_err1, 0);
    ticks(1'b1, 23);
    frame(9'h107, 9, 1'b1, 9);
    chk("p1_valid", valid1, 1);
    chk("p1_data", data1, 8'h07);
    chk("p1_perr", parity_err1, 0);
    ticks(1'b1, 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
